// File: rtl/regfile_access_ctrl.sv
// Operand-fetch controller for a 16x32 negedge-write / posedge-read register file.
// Scoreboards pending destinations to stall RAW/WAW hazards and hands operands to execute.
module regfile_access_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_rs1,
  input  logic [ADDR_W-1:0]        req_rs2,
  input  logic [ADDR_W-1:0]        req_rd,
  input  logic                     req_wb,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [DATA_W-1:0]        op_a,
  output logic [DATA_W-1:0]        op_b,
  output logic [ADDR_W-1:0]        op_rd,
  output logic                     op_wb,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     rf_rd_allow,
  output logic [ADDR_W-1:0]        rf_Rs1,
  output logic [ADDR_W-1:0]        rf_Rs2,
  output logic                     rf_wr_allow,
  output logic [ADDR_W-1:0]        rf_Rd,
  output logic [DATA_W-1:0]        rf_DI,
  input  logic [DATA_W-1:0]        rf_D1,
  input  logic [DATA_W-1:0]        rf_D2,
  output logic [(1<<ADDR_W)-1:0]   pending,
  output logic                     wb_err
);

  localparam int unsigned NumRegs = 1 << ADDR_W;
  localparam logic [NumRegs-1:0] OneBit = {{(NumRegs-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StCapt, StOut} state_e;

  state_e state_q, state_d;

  logic [NumRegs-1:0] pending_q, pending_d;
  logic               wb_err_q, wb_err_d;
  logic               op_valid_q, op_valid_d;
  logic [DATA_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ADDR_W-1:0]  op_rd_q, op_rd_d;
  logic               op_wb_q, op_wb_d;

  logic [NumRegs-1:0] clr, set, pend_eff;
  logic               hazard, accept;

  // A same-cycle writeback lands on negedge before the posedge read, so it clears the hazard.
  assign clr      = wb_valid ? (OneBit << wb_rd) : '0;
  assign pend_eff = pending_q & ~clr;
  assign hazard   = pend_eff[req_rs1] | pend_eff[req_rs2] | (req_wb & pend_eff[req_rd]);
  assign accept   = req_valid & req_ready;
  assign set      = (accept & req_wb) ? (OneBit << req_rd) : '0;

  assign rf_wr_allow = wb_valid & ~rst;
  assign rf_Rd       = wb_rd;
  assign rf_DI       = wb_data;
  assign rf_Rs1      = req_rs1;
  assign rf_Rs2      = req_rs2;

  assign pending  = pending_q;
  assign wb_err   = wb_err_q;
  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_rd    = op_rd_q;
  assign op_wb    = op_wb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCapt;
      StCapt:  state_d = StOut;
      StOut:   if (op_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    rf_rd_allow = 1'b0;
    if (!rst && state_q == StIdle) begin
      req_ready   = ~hazard;
      rf_rd_allow = req_valid & ~hazard;
    end
  end

  always_comb begin
    pending_d  = (pending_q & ~clr) | set;
    wb_err_d   = wb_err_q | (wb_valid & ~pending_q[wb_rd]);
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_rd_d    = op_rd_q;
    op_wb_d    = op_wb_q;
    if (accept) begin
      op_rd_d = req_rd;
      op_wb_d = req_wb;
    end
    if (state_q == StCapt) begin
      op_a_d     = rf_D1;
      op_b_d     = rf_D2;
      op_valid_d = 1'b1;
    end
    if (state_q == StOut && op_ready) begin
      op_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      wb_err_q   <= 1'b0;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_rd_q    <= '0;
      op_wb_q    <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      wb_err_q   <= wb_err_d;
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_rd_q    <= op_rd_d;
      op_wb_q    <= op_wb_d;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: register-file model, behavioural scoreboard/latency model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wb;
  logic [3:0]  req_rs1, req_rs2, req_rd;
  logic        op_valid, op_ready, op_wb;
  logic [31:0] op_a, op_b;
  logic [3:0]  op_rd;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rf_rd_allow, rf_wr_allow;
  logic [3:0]  rf_Rs1, rf_Rs2, rf_Rd;
  logic [31:0] rf_DI, rf_D1, rf_D2;
  logic [15:0] pending;
  logic        wb_err;

  always #5 clk = ~clk;

  regfile_access_ctrl #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rd(req_rd), .req_wb(req_wb),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
    .op_wb(op_wb),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_rd_allow(rf_rd_allow), .rf_Rs1(rf_Rs1), .rf_Rs2(rf_Rs2), .rf_wr_allow(rf_wr_allow),
    .rf_Rd(rf_Rd), .rf_DI(rf_DI), .rf_D1(rf_D1), .rf_D2(rf_D2),
    .pending(pending), .wb_err(wb_err)
  );

  // Register file: unwritten entries read as index*0x11.
  logic [31:0] rf [16];
  bit   [15:0] rf_written;

  function automatic logic [31:0] rf_val(input logic [3:0] r);
    return rf_written[r] ? rf[r] : 32'(r) * 32'h11;
  endfunction

  always @(negedge clk) begin
    if (rf_wr_allow) begin
      rf[rf_Rd]         <= rf_DI;
      rf_written[rf_Rd] <= 1'b1;
    end
  end

  always @(posedge clk) begin
    rf_D1 <= rf_rd_allow ? rf_val(rf_Rs1) : 32'h0;
    rf_D2 <= rf_rd_allow ? rf_val(rf_Rs2) : 32'h0;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural register contents, scoreboard, one in-flight operand set.
  logic [31:0] mrf [16];
  bit   [15:0] m_written;
  bit   [15:0] m_pend;
  bit          m_err;
  bit          m_busy;
  int          m_age;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_rd;
  bit          m_wb;

  function automatic logic [31:0] m_val(input logic [3:0] r);
    return m_written[r] ? mrf[r] : 32'(r) * 32'h11;
  endfunction

  function automatic bit m_ready();
    logic [15:0] pe;
    pe = m_pend & ~(wb_valid ? (16'h0001 << wb_rd) : 16'h0000);
    return !rst && !m_busy && !(pe[req_rs1] || pe[req_rs2] || (req_wb && pe[req_rd]));
  endfunction

  initial begin
    bit exp_ready, exp_valid, acc, deliver;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_ready = m_ready();
      exp_valid = m_busy && m_age >= 2;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("rf_rd_allow", 32'(rf_rd_allow), 32'(exp_ready && req_valid));
      check("rf_wr_allow", 32'(rf_wr_allow), 32'(!rst && wb_valid));
      check("rf_Rs1", 32'(rf_Rs1), 32'(req_rs1));
      check("rf_Rs2", 32'(rf_Rs2), 32'(req_rs2));
      check("rf_Rd", 32'(rf_Rd), 32'(wb_rd));
      check("rf_DI", rf_DI, wb_data);
      check("pending", 32'(pending), 32'(m_pend));
      check("wb_err", 32'(wb_err), 32'(m_err));
      check("op_valid", 32'(op_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("op_a", op_a, m_a);
        check("op_b", op_b, m_b);
        check("op_rd", 32'(op_rd), 32'(m_rd));
        check("op_wb", 32'(op_wb), 32'(m_wb));
      end
      if (rst) begin
        m_pend = '0; m_err = 1'b0; m_busy = 1'b0; m_age = 0;
      end else begin
        acc     = req_valid && exp_ready;
        deliver = exp_valid && op_ready;
        if (wb_valid) begin
          if (!m_pend[wb_rd]) m_err = 1'b1;
          m_pend[wb_rd]    = 1'b0;
          mrf[wb_rd]       = wb_data;
          m_written[wb_rd] = 1'b1;
        end
        if (acc) begin
          if (req_wb) m_pend[req_rd] = 1'b1;
          m_busy = 1'b1; m_age = 1;
          m_a = m_val(req_rs1); m_b = m_val(req_rs2); m_rd = req_rd; m_wb = req_wb;
        end else if (deliver) begin
          m_busy = 1'b0;
        end else if (m_busy) begin
          m_age++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit v, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input bit wb);
    req_valid = v; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_wb = wb;
  endtask

  initial begin
    bit acc;
    int idx;
    rst = 1'b1; op_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    set_req(1'b1, 4'd1, 4'd2, 4'd3, 1'b1);
    tick(); tick();
    #1;
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_op_valid", 32'(op_valid), 32'h0);
    check("rst_wb_err", 32'(wb_err), 32'h0);
    check("rst_op_a", op_a, 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    set_req(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);

    // Writeback to a register nobody is waiting on.
    tick();
    rst = 1'b0; wb_valid = 1'b1; wb_rd = 4'd3; wb_data = 32'h0000_00AA;
    #1 check("wb_allow", 32'(rf_wr_allow), 32'h1);
    tick();
    wb_valid = 1'b0;
    #1 check("wb_err_set", 32'(wb_err), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Basic issue and 4-cycle backpressure.
    set_req(1'b1, 4'd1, 4'd2, 4'd5, 1'b1);
    #1 check("issue_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0;
    tick();
    #1;
    check("issue_op_valid", 32'(op_valid), 32'h1);
    check("issue_op_a", op_a, 32'h11);
    check("issue_op_b", op_b, 32'h22);
    check("issue_op_rd", 32'(op_rd), 32'h5);
    check("issue_pending", 32'(pending), 32'h0020);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check("hold_valid", 32'(op_valid), 32'h1);
      check("hold_op_a", op_a, 32'h11);
      check("hold_op_b", op_b, 32'h22);
      check("hold_ready", 32'(req_ready), 32'h0);
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    #1 check("drained", 32'(op_valid), 32'h0);

    // RAW stall released by a same-cycle writeback.
    set_req(1'b1, 4'd5, 4'd0, 4'd6, 1'b0);
    #1 check("raw_stall0", 32'(req_ready), 32'h0);
    tick();
    #1 check("raw_stall1", 32'(req_ready), 32'h0);
    wb_valid = 1'b1; wb_rd = 4'd5; wb_data = 32'h1234;
    #1 check("raw_release", 32'(req_ready), 32'h1);
    tick();
    wb_valid = 1'b0; req_valid = 1'b0;
    tick();
    #1;
    check("raw_op_a", op_a, 32'h1234);
    check("raw_pending", 32'(pending), 32'h0);
    check("raw_no_err", 32'(wb_err), 32'h0);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;

    // WAW stall; clear and re-set of the same bit in one cycle.
    set_req(1'b1, 4'd0, 4'd0, 4'd7, 1'b1);
    tick();
    req_valid = 1'b0; op_ready = 1'b1;
    tick(); tick();
    op_ready = 1'b0;
    set_req(1'b1, 4'd0, 4'd0, 4'd7, 1'b1);
    #1 check("waw_stall", 32'(req_ready), 32'h0);
    tick();
    wb_valid = 1'b1; wb_rd = 4'd7; wb_data = 32'h77;
    #1 check("waw_release", 32'(req_ready), 32'h1);
    tick();
    wb_valid = 1'b0; req_valid = 1'b0;
    #1 check("waw_pending", 32'(pending), 32'h0080);
    op_ready = 1'b1;
    tick(); tick();
    op_ready = 1'b0;

    // Reset while capturing discards the in-flight request.
    set_req(1'b1, 4'd1, 4'd2, 4'd9, 1'b1);
    tick();
    req_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rstcap_valid", 32'(op_valid), 32'h0);
    check("rstcap_pending", 32'(pending), 32'h0);
    tick();
    #1;
    check("rstcap_stale", 32'(op_valid), 32'h0);
    check("rstcap_idle", 32'(req_ready), 32'h1);

    // Random traffic; requests held until accepted.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      tick();
      if (acc) req_valid = 1'b0;
      if (!req_valid && $urandom_range(0, 99) < 60) begin
        set_req(1'b1, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      rst      = ($urandom_range(0, 199) == 0);
      op_ready = 1'($urandom_range(0, 1));
      wb_valid = ($urandom_range(0, 99) < 35);
      wb_rd    = 4'($urandom_range(0, 15));
      wb_data  = $urandom;
      if (m_pend != 0 && $urandom_range(0, 99) < 80) begin
        idx = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++) begin
          if (m_pend[(idx + k) % 16]) begin
            wb_rd = 4'((idx + k) % 16);
            break;
          end
        end
      end
    end
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
